lfsr_offset_finder: RTL



---
 rtl/lfsr_finder_pkg.sv | 20 ++
 rtl/lfsr_step_reg.sv | 61 ++++++
 rtl/lfsr_offset_finder.sv | 215 +++++++++++++++++++++
 3 files changed

// File: rtl/lfsr_finder_pkg.sv
// -----------------------------------------------------------------------------
// lfsr_finder_pkg
// Shared definitions for the LFSR offset finder:
//   - LFSR_WIDTH     : width of LFSR state, target word and offset (17)
//   - LFSR_MAX_ITER  : default step budget, one full 17-bit m-sequence
//   - finder_state_e : search FSM states
// -----------------------------------------------------------------------------
package lfsr_finder_pkg;

    localparam int LFSR_WIDTH    = 17;
    localparam int LFSR_MAX_ITER = (1 << LFSR_WIDTH) - 1;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SEED   = 2'd1,
        SEARCH = 2'd2,
        REPORT = 2'd3
    } finder_state_e;

endpackage

// File: rtl/lfsr_step_reg.sv
// -----------------------------------------------------------------------------
// lfsr_step_reg
// Seed-loadable Fibonacci-style shift register. On step the state shifts left
// by one and the new LSB is the XOR-reduce of the state masked by the tap
// polynomial. Load has priority over step.
//
// Ports:
//   clk_i   : clock
//   rst_i   : asynchronous active-high reset (state cleared to 0)
//   load_i  : load seed_i into the state
//   seed_i  : seed value
//   step_i  : advance one LFSR step
//   poly_i  : feedback tap mask
//   state_o : current LFSR state
// -----------------------------------------------------------------------------
module lfsr_step_reg #(
    parameter int WIDTH = 17
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             load_i,
    input  logic [WIDTH-1:0] seed_i,
    input  logic             step_i,
    input  logic [WIDTH-1:0] poly_i,
    output logic [WIDTH-1:0] state_o
);

    logic [WIDTH-1:0] state_q;
    logic [WIDTH-1:0] state_d;
    logic [WIDTH-1:0] shifted;
    logic             feedback;

    assign feedback   = ^(state_q & poly_i);
    assign shifted[0] = feedback;

    generate
        for (genvar gi = 1; gi < WIDTH; gi++) begin : g_shift
            assign shifted[gi] = state_q[gi-1];
        end
    endgenerate

    always_comb begin
        state_d = state_q;
        if (load_i) begin
            state_d = seed_i;
        end else if (step_i) begin
            state_d = shifted;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q <= '0;
        end else begin
            state_q <= state_d;
        end
    end

    assign state_o = state_q;

endmodule

// File: rtl/lfsr_offset_finder.sv
// -----------------------------------------------------------------------------
// lfsr_offset_finder
// Steps a seeded LFSR until its state equals a captured sweep word and reports
// the number of steps taken (the sweep offset), or a miss once MAX_ITER states
// have been examined.
//
// Optional feature macro: LFSR_FINDER_ABORT_EN
//   When defined, an 'abort' input ends a search in SEED/SEARCH early with a
//   miss result (found=0, offset=0). Abort wins over a same-cycle match.
//
// Ports:
//   clk_72MHz  : sole clock
//   reset      : asynchronous active-high reset
//   polynomial : feedback tap mask, latched on accepted start
//   start_data : LFSR seed, latched on accepted start
//   target     : sweep word to find, latched on accepted start
//   start      : search request (accepted only in IDLE)
//   abort      : (LFSR_FINDER_ABORT_EN only) terminate current search
//   busy       : high from the cycle after accepted start through done
//   done       : one-cycle completion pulse
//   found      : match flag, held until the next accepted start
//   offset     : step count of the match, held with found
// -----------------------------------------------------------------------------
module lfsr_offset_finder
    import lfsr_finder_pkg::*;
#(
    parameter int WIDTH    = LFSR_WIDTH,
    parameter int MAX_ITER = LFSR_MAX_ITER
) (
    input  logic             clk_72MHz,
    input  logic             reset,
    input  logic [WIDTH-1:0] polynomial,
    input  logic [WIDTH-1:0] start_data,
    input  logic [WIDTH-1:0] target,
    input  logic             start,
`ifdef LFSR_FINDER_ABORT_EN
    input  logic             abort,
`endif
    output logic             busy,
    output logic             done,
    output logic             found,
    output logic [WIDTH-1:0] offset
);

    // Count value of the last state examined; checked before incrementing so
    // the counter never wraps.
    localparam logic [WIDTH-1:0] LAST_COUNT = WIDTH'(MAX_ITER - 1);

    finder_state_e    state_q;
    finder_state_e    state_d;

    logic [WIDTH-1:0] poly_q;
    logic [WIDTH-1:0] seed_q;
    logic [WIDTH-1:0] target_q;
    logic [WIDTH-1:0] count_q;
    logic [WIDTH-1:0] count_d;
    logic             found_q;
    logic             found_d;
    logic [WIDTH-1:0] offset_q;
    logic [WIDTH-1:0] offset_d;

    logic [WIDTH-1:0] lfsr_state;
    logic             accept;
    logic             lfsr_load;
    logic             lfsr_step;
    logic             match;
    logic             at_limit;
    logic             abort_hit;

`ifdef LFSR_FINDER_ABORT_EN
    assign abort_hit = abort;
`else
    assign abort_hit = 1'b0;
`endif

    assign accept   = (state_q == IDLE) && start;
    assign match    = (lfsr_state == target_q);
    assign at_limit = (count_q == LAST_COUNT);

    // ---------------------------------------------------------------------
    // LFSR datapath
    // ---------------------------------------------------------------------
    lfsr_step_reg #(
        .WIDTH (WIDTH)
    ) u_lfsr (
        .clk_i   (clk_72MHz),
        .rst_i   (reset),
        .load_i  (lfsr_load),
        .seed_i  (seed_q),
        .step_i  (lfsr_step),
        .poly_i  (poly_q),
        .state_o (lfsr_state)
    );

    // ---------------------------------------------------------------------
    // FSM: state register
    // ---------------------------------------------------------------------
    always_ff @(posedge clk_72MHz or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // ---------------------------------------------------------------------
    // FSM: next-state logic
    // ---------------------------------------------------------------------
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (start) begin
                    state_d = SEED;
                end
            end
            SEED: begin
                state_d = abort_hit ? REPORT : SEARCH;
            end
            SEARCH: begin
                if (abort_hit || match || at_limit) begin
                    state_d = REPORT;
                end
            end
            REPORT: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // ---------------------------------------------------------------------
    // FSM: outputs and datapath controls
    // ---------------------------------------------------------------------
    always_comb begin
        lfsr_load = 1'b0;
        lfsr_step = 1'b0;
        count_d   = count_q;
        found_d   = found_q;
        offset_d  = offset_q;
        case (state_q)
            IDLE: begin
                if (start) begin
                    found_d  = 1'b0;
                    offset_d = '0;
                end
            end
            SEED: begin
                lfsr_load = 1'b1;
                count_d   = '0;
                if (abort_hit) begin
                    found_d  = 1'b0;
                    offset_d = '0;
                end
            end
            SEARCH: begin
                // Priority: abort, then match, then limit, then step.
                if (abort_hit) begin
                    found_d  = 1'b0;
                    offset_d = '0;
                end else if (match) begin
                    found_d  = 1'b1;
                    offset_d = count_q;
                end else if (at_limit) begin
                    found_d  = 1'b0;
                    offset_d = '0;
                end else begin
                    lfsr_step = 1'b1;
                    count_d   = count_q + 1'b1;
                end
            end
            default: begin
            end
        endcase
    end

    assign busy   = (state_q != IDLE);
    assign done   = (state_q == REPORT);
    assign found  = found_q;
    assign offset = offset_q;

    // ---------------------------------------------------------------------
    // Operand latches: captured only when a start is accepted so input
    // changes during a search are invisible.
    // ---------------------------------------------------------------------
    always_ff @(posedge clk_72MHz or posedge reset) begin
        if (reset) begin
            poly_q   <= '0;
            seed_q   <= '0;
            target_q <= '0;
        end else if (accept) begin
            poly_q   <= polynomial;
            seed_q   <= start_data;
            target_q <= target;
        end
    end

    // ---------------------------------------------------------------------
    // Counter and result registers
    // ---------------------------------------------------------------------
    always_ff @(posedge clk_72MHz or posedge reset) begin
        if (reset) begin
            count_q  <= '0;
            found_q  <= 1'b0;
            offset_q <= '0;
        end else begin
            count_q  <= count_d;
            found_q  <= found_d;
            offset_q <= offset_d;
        end
    end

endmodule
